// File: rtl/wishbone_pkg.sv
// Shared types and defaults for the Wishbone splitter.
// Holds the FSM state encoding, default bus widths and the helper that
// sizes the peripheral index field.
package wishbone_pkg;

    localparam int WB_ADR_WIDTH = 16;
    localparam int WB_DAT_WIDTH = 8;

    // Splitter controller states
    //   state   | meaning
    //   ST_IDLE | waiting for a controller request
    //   ST_BUSY | selected peripheral strobed, waiting for its ack
    //   ST_RESP | one-cycle ack/err back to the controller
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    // Width of the index field in the top address bits; at least one bit
    // so a single-peripheral build still has an unmapped upper half.
    function automatic int peri_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wishbone_splitter_timer.sv
// Watchdog for the splitter BUSY state.
// Down-counter loaded with LIMIT-1 while cleared; o_expired flags the
// LIMIT-th consecutive enabled cycle.
module wishbone_splitter_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

    logic [CW-1:0] r_count;

    // Reload on clear, otherwise count down while enabled and stop at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= CW'(LIMIT - 1);
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = i_enable && !i_clear && (r_count == '0);

endmodule

// File: rtl/wishbone_splitter.sv
// Classic Wishbone 1-to-N splitter with a single outstanding transfer.
// The top PERI_BITS address bits select the peripheral; the remaining low
// bits, write enable and write data are broadcast from registered copies.
// Optional BUSY watchdog: define WISHBONE_SPLITTER_TIMEOUT_EN.
module wishbone_splitter
    import wishbone_pkg::*;
#(
    parameter int PERI_NUM       = 4,
    parameter int ADR_WIDTH      = WB_ADR_WIDTH,
    parameter int DAT_WIDTH      = WB_DAT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wbc_cyc,
    input  logic                                 wbc_stb,
    input  logic                                 wbc_we,
    input  logic [ADR_WIDTH-1:0]                 wbc_adr,
    input  logic [DAT_WIDTH-1:0]                 wbc_dat_w,
    output logic                                 wbc_ack,
    output logic                                 wbc_err,
    output logic [DAT_WIDTH-1:0]                 wbc_dat_r,
    output logic [PERI_NUM-1:0]                  wbp_cyc,
    output logic [PERI_NUM-1:0]                  wbp_stb,
    output logic                                 wbp_we,
    output logic [ADR_WIDTH-peri_bits(PERI_NUM)-1:0] wbp_adr,
    output logic [DAT_WIDTH-1:0]                 wbp_dat_w,
    input  logic [PERI_NUM-1:0]                  wbp_ack,
    input  logic [PERI_NUM*DAT_WIDTH-1:0]        wbp_dat_r
);

    localparam int PERI_BITS = peri_bits(PERI_NUM);
    localparam int LOW_BITS  = ADR_WIDTH - PERI_BITS;

    wb_state_t               r_state;
    logic [PERI_BITS-1:0]    r_idx;
    logic [PERI_NUM-1:0]     r_cyc;
    logic [PERI_NUM-1:0]     r_stb;
    logic                    r_we;
    logic [LOW_BITS-1:0]     r_adr;
    logic [DAT_WIDTH-1:0]    r_dat_w;
    logic [DAT_WIDTH-1:0]    r_dat_r;
    logic                    r_ack;
    logic                    r_err;

    logic [PERI_BITS-1:0]    w_req_idx;
    logic                    w_req_mapped;
    logic [PERI_NUM-1:0]     w_req_onehot;
    logic                    w_sel_ack;
    logic [DAT_WIDTH-1:0]    w_sel_dat;
    logic                    w_timeout;

    assign w_req_idx    = wbc_adr[ADR_WIDTH-1 -: PERI_BITS];
    assign w_req_mapped = ({1'b0, w_req_idx} < (PERI_BITS + 1)'(PERI_NUM));
    assign w_req_onehot = PERI_NUM'(1) << w_req_idx;

    // Pick ack and read data of the latched port only; other acks never reach the FSM
    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        for (int i = 0; i < PERI_NUM; i++) begin
            if (r_idx == PERI_BITS'(i)) begin
                w_sel_ack = wbp_ack[i];
                w_sel_dat = wbp_dat_r[i*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

`ifdef WISHBONE_SPLITTER_TIMEOUT_EN
    logic w_tmr_enable;
    logic w_tmr_clear;

    assign w_tmr_enable = (r_state == ST_BUSY);
    assign w_tmr_clear  = !w_tmr_enable;

    wishbone_splitter_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_enable),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Transfer FSM with all bus outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cyc   <= '0;
            r_stb   <= '0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat_w <= '0;
            r_dat_r <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wbc_cyc && wbc_stb) begin
                        r_idx   <= w_req_idx;
                        r_we    <= wbc_we;
                        r_adr   <= wbc_adr[LOW_BITS-1:0];
                        r_dat_w <= wbc_dat_w;
                        if (w_req_mapped) begin
                            r_cyc   <= w_req_onehot;
                            r_stb   <= w_req_onehot;
                            r_state <= ST_BUSY;
                        end else begin
                            r_err   <= 1'b1;
                            r_dat_r <= '0;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    // Controller abort wins over a simultaneous ack or timeout
                    if (!wbc_cyc) begin
                        r_cyc   <= '0;
                        r_stb   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_sel_ack) begin
                        r_cyc   <= '0;
                        r_stb   <= '0;
                        r_dat_r <= w_sel_dat;
                        r_ack   <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_cyc   <= '0;
                        r_stb   <= '0;
                        r_dat_r <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cyc   <= '0;
                    r_stb   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbc_ack   = r_ack;
    assign wbc_err   = r_err;
    assign wbc_dat_r = r_dat_r;
    assign wbp_cyc   = r_cyc;
    assign wbp_stb   = r_stb;
    assign wbp_we    = r_we;
    assign wbp_adr   = r_adr;
    assign wbp_dat_w = r_dat_w;

endmodule

// File: tb/tb_wishbone_splitter.sv
// Self-checking bench for wishbone_splitter: a transfer-timeline model drives
// random transfers and sets per-cycle expectations that one compare process
// checks on every falling edge; directed cases pin the model with literals.
module tb_wishbone_splitter;

    localparam int PN = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // 4-port instance
    logic        cyc, stb, we;
    logic [15:0] adr;
    logic [7:0]  dw;
    logic        ack, err;
    logic [7:0]  dr;
    logic [3:0]  pcyc, pstb, pack;
    logic        pwe;
    logic [13:0] padr;
    logic [7:0]  pdw;
    logic [31:0] pdr;

    // 3-port instance
    logic        q_cyc, q_stb, q_we;
    logic [15:0] q_adr;
    logic [7:0]  q_dw;
    logic        q_ack, q_err;
    logic [7:0]  q_dr;
    logic [2:0]  q_pcyc, q_pstb, q_pack;
    logic        q_pwe;
    logic [13:0] q_padr;
    logic [7:0]  q_pdw;
    logic [23:0] q_pdr;

    assign q_pack = q_pstb;
    assign q_pdr  = 24'h33_22_11;

    wishbone_splitter #(
        .PERI_NUM(PN), .ADR_WIDTH(16), .DAT_WIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wbc_cyc(cyc), .wbc_stb(stb), .wbc_we(we), .wbc_adr(adr), .wbc_dat_w(dw),
        .wbc_ack(ack), .wbc_err(err), .wbc_dat_r(dr),
        .wbp_cyc(pcyc), .wbp_stb(pstb), .wbp_we(pwe), .wbp_adr(padr),
        .wbp_dat_w(pdw), .wbp_ack(pack), .wbp_dat_r(pdr)
    );

    wishbone_splitter #(
        .PERI_NUM(3), .ADR_WIDTH(16), .DAT_WIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .wbc_cyc(q_cyc), .wbc_stb(q_stb), .wbc_we(q_we), .wbc_adr(q_adr), .wbc_dat_w(q_dw),
        .wbc_ack(q_ack), .wbc_err(q_err), .wbc_dat_r(q_dr),
        .wbp_cyc(q_pcyc), .wbp_stb(q_pstb), .wbp_we(q_pwe), .wbp_adr(q_padr),
        .wbp_dat_w(q_pdw), .wbp_ack(q_pack), .wbp_dat_r(q_pdr)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs of the 4-port instance for the current cycle
    bit          chk_en = 1'b0;
    logic [3:0]  e_stb  = '0;
    logic        e_ack  = 1'b0;
    logic        e_err  = 1'b0;
    logic [7:0]  e_dr   = '0;
    logic        e_busy = 1'b0;
    logic        e_we   = 1'b0;
    logic [13:0] e_adr  = '0;
    logic [7:0]  e_dw   = '0;

    logic [7:0]  pd [PN];

    // Observations of the most recent transfer
    int          obs_ack_c, obs_ack_n, obs_err_c, obs_err_n, obs_busy_n;
    logic [3:0]  obs_stb;
    logic [13:0] obs_adr;
    logic [7:0]  obs_dw, obs_dr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wbc_ack", 32'(ack), 32'(e_ack));
            chk("wbc_err", 32'(err), 32'(e_err));
            chk("wbc_dat_r", 32'(dr), 32'(e_dr));
            chk("wbp_cyc", 32'(pcyc), 32'(e_stb));
            chk("wbp_stb", 32'(pstb), 32'(e_stb));
            if (e_busy) begin
                chk("wbp_we", 32'(pwe), 32'(e_we));
                chk("wbp_adr", 32'(padr), 32'(e_adr));
                chk("wbp_dat_w", 32'(pdw), 32'(e_dw));
            end
        end
    end

    task automatic obs_clear();
        obs_ack_c = -1; obs_ack_n = 0; obs_err_c = -1; obs_err_n = 0; obs_busy_n = 0;
        obs_stb = '0; obs_adr = '0; obs_dw = '0; obs_dr = '0;
    endtask

    task automatic observe(input int c, input logic [3:0] oh);
        if (ack) begin
            obs_ack_n++;
            if (obs_ack_c < 0) obs_ack_c = c;
            obs_dr = dr;
        end
        if (err) begin
            obs_err_n++;
            if (obs_err_c < 0) obs_err_c = c;
            obs_dr = dr;
        end
        if (pstb == oh) obs_busy_n++;
        if (c == 1) begin
            obs_stb = pstb; obs_adr = padr; obs_dw = pdw;
        end
    endtask

    task automatic new_pdata();
        for (int i = 0; i < PN; i++) pd[i] = 8'($urandom);
        pdr = {pd[3], pd[2], pd[1], pd[0]};
    endtask

    task automatic set_idle_exp();
        e_busy = 1'b0; e_stb = '0; e_ack = 1'b0; e_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            cyc = 1'b0; stb = $urandom_range(0, 1) == 1;
            adr = 16'($urandom); dw = 8'($urandom); we = 1'($urandom);
            cyc = 1'b0;
            set_idle_exp();
            pack = 4'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Normal transfer: request in cycle 0, ws wait states, ack in cycle 2+ws.
    // The controller keeps its request up through the ack cycle, as a classic
    // master would, and releases it afterwards.
    task automatic xfer(input int idx, input bit w, input logic [13:0] lo,
                        input logic [7:0] wd, input int ws, input int fixed_rd);
        logic [3:0] oh;
        int resp;
        oh   = 4'b0001 << idx;
        resp = 2 + ws;
        new_pdata();
        if (fixed_rd >= 0) begin
            pd[idx] = 8'(fixed_rd);
            pdr = {pd[3], pd[2], pd[1], pd[0]};
        end
        obs_clear();
        for (int c = 0; c <= resp + 1; c++) begin
            cyc = (c <= resp); stb = (c <= resp);
            we = w; adr = {2'(idx), lo}; dw = wd;
            e_busy = (c >= 1) && (c <= 1 + ws);
            e_stb  = e_busy ? oh : 4'b0;
            e_we = w; e_adr = lo; e_dw = wd;
            e_ack = (c == resp); e_err = 1'b0;
            if (c == resp) e_dr = pd[idx];
            pack = ((e_busy && (c == 1 + ws)) ? oh : 4'b0) | (4'($urandom) & ~oh);
            @(negedge clk);
            observe(c, oh);
            @(posedge clk); #1;
        end
    endtask

    // Controller drops cyc in the k-th BUSY cycle while the port never acks
    task automatic abort_xfer(input int idx, input int k);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        new_pdata();
        obs_clear();
        for (int c = 0; c <= k + 2; c++) begin
            cyc = (c < k); stb = (c < k);
            we = 1'b1; adr = {2'(idx), 14'h1234}; dw = 8'h5A;
            e_busy = (c >= 1) && (c <= k);
            e_stb  = e_busy ? oh : 4'b0;
            e_we = 1'b1; e_adr = 14'h1234; e_dw = 8'h5A;
            e_ack = 1'b0; e_err = 1'b0;
            pack = 4'($urandom) & ~oh;
            @(negedge clk);
            observe(c, oh);
            @(posedge clk); #1;
        end
    endtask

    // Reset pulse sampled at the end of the k-th BUSY cycle
    task automatic reset_xfer(input int idx, input int k);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        new_pdata();
        obs_clear();
        for (int c = 0; c <= k + 1; c++) begin
            rst_n = !(c == k);
            cyc = (c <= k); stb = (c <= k);
            we = 1'b1; adr = {2'(idx), 14'h2AAA}; dw = 8'hC3;
            e_busy = (c >= 1) && (c <= k);
            e_stb  = e_busy ? oh : 4'b0;
            e_we = 1'b1; e_adr = 14'h2AAA; e_dw = 8'hC3;
            e_ack = 1'b0; e_err = 1'b0;
            if (c == k + 1) e_dr = '0;
            pack = 4'($urandom) & ~oh;
            @(negedge clk);
            observe(c, oh);
            if (c == k + 1) begin
                chk("rst_wbp_we", 32'(pwe), 32'd0);
                chk("rst_wbp_adr", 32'(padr), 32'd0);
                chk("rst_wbp_dat_w", 32'(pdw), 32'd0);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    // Port never acks: watchdog error, or an indefinite wait ended by abort
    task automatic no_ack(input int idx, input int busy_len, input bit expect_err);
        logic [3:0] oh;
        int drop_c, last;
        oh = 4'b0001 << idx;
        drop_c = expect_err ? busy_len + 2 : busy_len;
        last   = expect_err ? busy_len + 2 : busy_len + 1;
        new_pdata();
        obs_clear();
        for (int c = 0; c <= last; c++) begin
            cyc = (c < drop_c); stb = (c < drop_c);
            we = 1'b0; adr = {2'(idx), 14'h0077}; dw = 8'h00;
            e_busy = (c >= 1) && (c <= busy_len);
            e_stb  = e_busy ? oh : 4'b0;
            e_we = 1'b0; e_adr = 14'h0077; e_dw = 8'h00;
            e_ack = 1'b0;
            e_err = expect_err && (c == busy_len + 1);
            if (e_err) e_dr = '0;
            pack = 4'($urandom) & ~oh;
            @(negedge clk);
            observe(c, oh);
            @(posedge clk); #1;
        end
    endtask

    task automatic dut3_test();
        int ack_c, ack_n, err_c, err_n, strobed;
        logic [7:0] d_seen;
        // mapped zero-wait read from port 2
        ack_c = -1; ack_n = 0; d_seen = '0;
        for (int c = 0; c <= 3; c++) begin
            q_adr = 16'h8000; q_we = 1'b0; q_dw = '0;
            q_cyc = (c <= 2); q_stb = (c <= 2);
            @(negedge clk);
            if (q_ack) begin
                ack_n++;
                if (ack_c < 0) ack_c = c;
                d_seen = q_dr;
            end
            @(posedge clk); #1;
        end
        chk("p3_map_latency", 32'(ack_c), 32'd2);
        chk("p3_map_acks", 32'(ack_n), 32'd1);
        chk("p3_map_dat_r", 32'(d_seen), 32'h33);
        // index 3 is unmapped in a 3-port build
        ack_n = 0; err_c = -1; err_n = 0; strobed = 0; d_seen = 8'hFF;
        for (int c = 0; c <= 4; c++) begin
            q_adr = 16'hC000; q_we = 1'b1; q_dw = 8'h99;
            q_cyc = (c <= 1); q_stb = (c <= 1);
            @(negedge clk);
            if ((q_pstb != '0) || (q_pcyc != '0)) strobed++;
            if (q_ack) ack_n++;
            if (q_err) begin
                err_n++;
                if (err_c < 0) err_c = c;
                d_seen = q_dr;
            end
            @(posedge clk); #1;
        end
        chk("p3_unmapped_strobes", 32'(strobed), 32'd0);
        chk("p3_unmapped_err_count", 32'(err_n), 32'd1);
        chk("p3_unmapped_err_cycle", 32'(err_c), 32'd1);
        chk("p3_unmapped_acks", 32'(ack_n), 32'd0);
        chk("p3_unmapped_dat_r", 32'(d_seen), 32'd0);
        q_cyc = 1'b0; q_stb = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int busy_len;
        bit expect_err;
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dw = '0; pack = '0; pdr = '0;
        q_cyc = 1'b0; q_stb = 1'b0; q_we = 1'b0; q_adr = '0; q_dw = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_wbp_adr", 32'(padr), 32'd0);
        chk("reset_wbc_dat_r", 32'(dr), 32'd0);
        chk("reset_wbp_stb", 32'(pstb), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // top address bits 01 select port 1
        xfer(1, 1'b1, 14'h0012, 8'hA5, 0, -1);
        chk("w4012_wbp_stb", 32'(obs_stb), 32'b0010);
        chk("w4012_wbp_adr", 32'(obs_adr), 32'h0012);
        chk("w4012_wbp_dat_w", 32'(obs_dw), 32'hA5);
        chk("w4012_latency", 32'(obs_ack_c), 32'd2);
        chk("w4012_ack_count", 32'(obs_ack_n), 32'd1);
        chk("w4012_err_count", 32'(obs_err_n), 32'd0);
        idle(1);

        xfer(3, 1'b0, 14'h0003, 8'h00, 2, 8'h3C);
        chk("rC003_latency", 32'(obs_ack_c), 32'd4);
        chk("rC003_dat_r", 32'(obs_dr), 32'h3C);
        chk("rC003_ack_count", 32'(obs_ack_n), 32'd1);
        idle(2);

        dut3_test();
        idle(1);

`ifdef WISHBONE_SPLITTER_TIMEOUT_EN
        busy_len = TO; expect_err = 1'b1;
`else
        busy_len = 1000; expect_err = 1'b0;
`endif
        xfer(2, 1'b0, 14'h0101, 8'h00, 1, 8'hE7);
        no_ack(1, busy_len, expect_err);
        chk("noack_busy_cycles", 32'(obs_busy_n), 32'(busy_len));
        chk("noack_err_count", 32'(obs_err_n), expect_err ? 32'd1 : 32'd0);
        chk("noack_ack_count", 32'(obs_ack_n), 32'd0);
        if (expect_err) chk("noack_err_cycle", 32'(obs_err_c), 32'(busy_len + 1));
        idle(1);

        abort_xfer(2, 3);
        chk("abort_ack_err", 32'(obs_ack_n + obs_err_n), 32'd0);
        xfer(0, 1'b0, 14'h0040, 8'h00, 1, -1);
        chk("after_abort_ack", 32'(obs_ack_n), 32'd1);
        chk("after_abort_latency", 32'(obs_ack_c), 32'd3);
        idle(1);

        reset_xfer(3, 2);
        chk("reset_ack_err", 32'(obs_ack_n + obs_err_n), 32'd0);
        xfer(0, 1'b1, 14'h0005, 8'h6E, 0, -1);
        chk("after_reset_ack", 32'(obs_ack_n), 32'd1);
        chk("after_reset_latency", 32'(obs_ack_c), 32'd2);
        idle(1);

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                abort_xfer($urandom_range(0, PN - 1), $urandom_range(1, 5));
            end else begin
                xfer($urandom_range(0, PN - 1), 1'($urandom), 14'($urandom),
                     8'($urandom), $urandom_range(0, 5), -1);
            end
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
